// File: rtl/ram_param.sv
`timescale 1ns / 1ps
// ram_param: parameterised single-port synchronous RAM.
// Features: ready/valid read pipeline (latency 1 or 2), read-first or
// write-first behaviour on a same-cycle read and write, and an optional
// hardware clear of the whole array after reset.
module ram_param #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned READ_MODE      = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  wen,
  input  logic                  ren,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  qvalid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_READY = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

  // Only latencies of 1 and 2 are implemented.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_param: READ_LATENCY must be 1 or 2");
  end

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc_c;
  logic                    rd_acc_c;
  logic [DATA_WIDTH-1:0]   rd_data_c;

  // Request acceptance: requests only count while the array is in service.
  always_comb begin
    wr_acc_c = (state == ST_RUN) && wen;
    rd_acc_c = (state == ST_RUN) && ren;
  end

  // Read data selection: a same-cycle write always targets the read address,
  // so write-first simply forwards datain.
  always_comb begin
    rd_data_c = mem[address];
    if ((READ_MODE != 0) && wen) begin
      rd_data_c = datain;
    end
  end

  // Control FSM: sweep the clear counter in INIT, then serve requests in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
      ready   <= RESET_READY;
    end else begin
      case (state)
        ST_INIT: begin
          ready <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= RESET_STATE;
          ready <= RESET_READY;
        end
      endcase
    end
  end

  // Storage array: cleared word by word in INIT, written by accepted writes.
  // The array has no reset of its own; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_acc_c) begin
        mem[address] <= datain;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // Single-stage read: q/qvalid load at the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q      <= '0;
        qvalid <= 1'b0;
      end else begin
        qvalid <= rd_acc_c;
        if (rd_acc_c) begin
          q <= rd_data_c;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;

    // First read stage: capture data at the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s_data  <= '0;
        s_valid <= 1'b0;
      end else begin
        s_valid <= rd_acc_c;
        if (rd_acc_c) begin
          s_data <= rd_data_c;
        end
      end
    end

    // Output stage: q holds its value unless a read completes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q      <= '0;
        qvalid <= 1'b0;
      end else begin
        qvalid <= s_valid;
        if (s_valid) begin
          q <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_param.sv
`timescale 1ns / 1ps
// tb_ram_param: directed checks of ram_param with two cleared instances
// (latency 1 read-first, latency 2 write-first) and one non-clearing instance.
module tb_ram_param;

  logic       clk;
  logic       reset;
  logic [3:0] address;
  logic [7:0] datain;
  logic       wen;
  logic       ren;

  logic       ready_a, qvalid_a;
  logic [7:0] q_a;
  logic       ready_b, qvalid_b;
  logic [7:0] q_b;
  logic       ready_c, qvalid_c;
  logic [7:0] q_c;

  int checks = 0;
  int errors = 0;

  ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1), .READ_MODE(0),
              .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .address(address), .datain(datain),
    .wen(wen), .ren(ren), .ready(ready_a), .q(q_a), .qvalid(qvalid_a));

  ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2), .READ_MODE(1),
              .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(reset), .address(address), .datain(datain),
    .wen(wen), .ren(ren), .ready(ready_b), .q(q_b), .qvalid(qvalid_b));

  ram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1), .READ_MODE(0),
              .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .reset(reset), .address(address), .datain(datain),
    .wen(wen), .ren(ren), .ready(ready_c), .q(q_c), .qvalid(qvalid_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single write, driven on a falling edge and accepted on the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wen = 1'b1; address = a; datain = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  // Single read; checks u_a one cycle after, u_b two cycles after.
  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [7:0] exp_a, input logic [7:0] exp_b);
    @(negedge clk);
    ren = 1'b1; address = a;
    @(negedge clk);
    ren = 1'b0;
    chk({tag, " q_a"}, 32'(q_a), 32'(exp_a));
    chk({tag, " qvalid_a"}, 32'(qvalid_a), 32'd1);
    @(negedge clk);
    chk({tag, " qvalid_a drop"}, 32'(qvalid_a), 32'd0);
    chk({tag, " q_b"}, 32'(q_b), 32'(exp_b));
    chk({tag, " qvalid_b"}, 32'(qvalid_b), 32'd1);
  endtask

  // Wait out the clear sweep; returns cycles with ready low and any qvalid seen.
  task automatic wait_clear(output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (!ready_a && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (qvalid_a || qvalid_b) seen = 1'b1;
    end
  endtask

  initial begin
    int         cnt;
    logic       seen;
    logic [7:0] sq_a [6];
    logic [7:0] sq_b [6];
    logic       sv_a [6];
    logic       sv_b [6];

    reset = 1'b0; address = '0; datain = '0; wen = 1'b0; ren = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst ready_a", 32'(ready_a), 32'd0);
    chk("rst ready_b", 32'(ready_b), 32'd0);
    chk("rst ready_c", 32'(ready_c), 32'd1);
    chk("rst q_a", 32'(q_a), 32'd0);
    chk("rst qvalid_a", 32'(qvalid_a), 32'd0);
    chk("rst q_b", 32'(q_b), 32'd0);
    chk("rst qvalid_b", 32'(qvalid_b), 32'd0);
    chk("rst q_c", 32'(q_c), 32'd0);
    chk("rst qvalid_c", 32'(qvalid_c), 32'd0);

    // Requests held during INIT must be ignored
    wen = 1'b1; ren = 1'b1; address = 4'd5; datain = 8'hAA;
    @(negedge clk);
    reset = 1'b0;
    wait_clear(cnt, seen);
    wen = 1'b0; ren = 1'b0;
    chk("init ready cycles", 32'(cnt), 32'd16);
    chk("init ready_b", 32'(ready_b), 32'd1);
    chk("init no qvalid", 32'(seen), 32'd0);
    rd("init addr5", 4'd5, 8'h00, 8'h00);

    // Basic write/read
    wr(4'd0, 8'd2);
    wr(4'd1, 8'd255);
    rd("basic addr1", 4'd1, 8'd255, 8'd255);
    rd("basic addr0", 4'd0, 8'd2, 8'd2);
    @(negedge clk);
    chk("hold q_a", 32'(q_a), 32'd2);
    chk("hold qvalid_a", 32'(qvalid_a), 32'd0);
    chk("hold q_b", 32'(q_b), 32'd2);
    chk("hold qvalid_b", 32'(qvalid_b), 32'd0);

    // Read-during-write: u_a read-first, u_b write-first
    wr(4'd3, 8'h11);
    @(negedge clk);
    wen = 1'b1; ren = 1'b1; address = 4'd3; datain = 8'h22;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    chk("rdw q_a old", 32'(q_a), 32'h11);
    chk("rdw qvalid_a", 32'(qvalid_a), 32'd1);
    @(negedge clk);
    chk("rdw q_b new", 32'(q_b), 32'h22);
    chk("rdw qvalid_b", 32'(qvalid_b), 32'd1);
    rd("rdw reread", 4'd3, 8'h22, 8'h22);

    // Back-to-back reads of addresses 0,1,2
    wr(4'd2, 8'h5A);
    @(negedge clk);
    ren = 1'b1; address = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sq_a[i] = q_a; sv_a[i] = qvalid_a;
      sq_b[i] = q_b; sv_b[i] = qvalid_b;
      if (i == 0) address = 4'd1;
      else if (i == 1) address = 4'd2;
      else ren = 1'b0;
    end
    chk("pipe a v0", 32'(sv_a[0]), 32'd1);
    chk("pipe a q0", 32'(sq_a[0]), 32'd2);
    chk("pipe a v1", 32'(sv_a[1]), 32'd1);
    chk("pipe a q1", 32'(sq_a[1]), 32'd255);
    chk("pipe a v2", 32'(sv_a[2]), 32'd1);
    chk("pipe a q2", 32'(sq_a[2]), 32'h5A);
    chk("pipe a v3", 32'(sv_a[3]), 32'd0);
    chk("pipe a q3 hold", 32'(sq_a[3]), 32'h5A);
    chk("pipe b v0", 32'(sv_b[0]), 32'd0);
    chk("pipe b v1", 32'(sv_b[1]), 32'd1);
    chk("pipe b q1", 32'(sq_b[1]), 32'd2);
    chk("pipe b v2", 32'(sv_b[2]), 32'd1);
    chk("pipe b q2", 32'(sq_b[2]), 32'd255);
    chk("pipe b v3", 32'(sv_b[3]), 32'd1);
    chk("pipe b q3", 32'(sq_b[3]), 32'h5A);
    chk("pipe b v4", 32'(sv_b[4]), 32'd0);
    chk("pipe b v5", 32'(sv_b[5]), 32'd0);
    chk("pipe b q5 hold", 32'(sq_b[5]), 32'h5A);

    // Reset in the middle of a latency-2 read, with garbage in the array
    wr(4'd0, 8'h77);
    wr(4'd15, 8'h99);
    @(negedge clk);
    ren = 1'b1; address = 4'd0;
    @(posedge clk);
    #1;
    chk("pre-rst q_a", 32'(q_a), 32'h77);
    chk("pre-rst qvalid_a", 32'(qvalid_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async q_a", 32'(q_a), 32'd0);
    chk("async qvalid_a", 32'(qvalid_a), 32'd0);
    chk("async q_b", 32'(q_b), 32'd0);
    chk("async qvalid_b", 32'(qvalid_b), 32'd0);
    chk("async ready_a", 32'(ready_a), 32'd0);
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_clear(cnt, seen);
    chk("reclear ready cycles", 32'(cnt), 32'd16);
    chk("reclear no qvalid", 32'(seen), 32'd0);
    chk("reclear q_b", 32'(q_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd($sformatf("clear addr%0d", i), 4'(i), 8'h00, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
